mips_trace_buffer: RTL
======================

// Module: mips_trace_buffer
// PURPOSE
//   Synthesizable execution-trace capture for the single-cycle MIPS core: records one entry per retired instruction
//   (timestamp, pc, instruction, register write-back) into a circular buffer. Capture is armed, triggered on a PC
//   match, and runs for a programmable post-trigger count. The frozen buffer then drains oldest-first over a
//   valid/ready port. Sits beside the mips top level, fed from its pc/instruction/write-back nets.
// PARAMETERS
//   ADDR_W  32  pc width
//   DATA_W  32  write_data width
//   DEPTH   16  entries; power of 2, >=2
//   TS_W    16  timestamp width (cycles since arm, saturating)
// PORTS
//   clock        in   1        rising-edge clock
//   reset_n      in   1        asynchronous, active-low reset
//   trace_valid  in   1        one instruction retires this cycle
//   pc           in   ADDR_W   pc of retiring instruction
//   instruction  in   32       retiring instruction word
//   reg_write    in   1        register-file write enable of retiring instruction
//   write_reg    in   5        destination register
//   write_data   in   DATA_W   write-back data
//   arm          in   1        pulse: clear buffer, enter ARMED
//   abort        in   1        pulse: freeze immediately, enter DONE
//   trig_en      in   1        1: trigger on pc==trig_pc; 0: trigger on first valid
//   trig_pc      in   ADDR_W   trigger address
//   post_count   in   clog2(DEPTH)  entries captured after trigger entry
//   rd_valid     out  1        DONE and count!=0
//   rd_ready     in   1        consumer accepts rd_data
//   rd_data      out  TS_W+ADDR_W+38+DATA_W  {ts,pc,instruction,reg_write,write_reg,write_data} of oldest entry
//   state        out  2        00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   count        out  clog2(DEPTH)+1  valid entries held
//   overflow     out  1        an unread entry was overwritten since arm
//   triggered    out  1        trigger hit since arm
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, wr/rd pointers=0, ts=0, overflow=0, triggered=0, rd_valid=0, rd_data=0.
//     Memory contents are not reset.
//   - Priority each cycle: abort > arm > capture/readout.
//   - arm (any state): pointers=0, count=0, ts=0, overflow=0, triggered=0, state->ARMED. A trace_valid in the
//     same cycle is not captured.
//   - abort (any state): state->DONE; contents, count and flags kept. A trace_valid in the same cycle is not captured.
//   - ts: increments each cycle in ARMED/POST; saturates at all-ones; holds in IDLE/DONE.
//   - ARMED: each trace_valid writes the entry at wr_ptr and sets wr_ptr+1 (mod DEPTH). If count<DEPTH, count+1.
//     Else rd_ptr+1 and overflow=1, so the oldest entry is overwritten.
//   - Trigger: trace_valid in ARMED with (trig_en==0 or pc==trig_pc). The entry is captured, triggered=1,
//     remaining=post_count. If post_count==0 -> DONE, else -> POST. Trigger config is sampled on the trigger cycle only.
//   - post_count is clamped to DEPTH-1 so the trigger entry survives.
//   - POST: same write rule as ARMED, plus remaining-1 per valid. The write that takes remaining to 0 is captured
//     and state->DONE on the next edge.
//   - DONE: no capture. rd_valid=(count!=0). rd_data=mem[rd_ptr], combinational, zero latency.
//     rd_valid&&rd_ready pops the entry (rd_ptr+1, count-1). rd_data must stay stable while rd_valid&&!rd_ready.
//     The buffer empties and stays in DONE until arm.
//   - IDLE: no capture. rd_valid=0.
//   - Write-pointer wrap and read-pointer wrap are both mod DEPTH; count never exceeds DEPTH.
// TESTING
//   1 reset mid-POST (reset_n low 1 cycle) -> state=IDLE, count=0, triggered=0, rd_valid=0, asynchronously.
//   2 DEPTH=16, trig_en=1, trig_pc=0x40, post_count=3, pc stream 0x00,0x04..0x50 (valid every cycle)
//     -> DONE after pc 0x4C is captured; count=16; overflow=1; first rd_data.pc=0x10, last=0x4C.
//   3 trig_en=0, post_count=0 -> one entry captured (first valid), state=DONE, count=1, overflow=0.
//   4 arm, 5 valids, abort -> DONE, count=5, triggered=0. Drain with rd_ready toggling 1,0,1 -> data held when
//     rd_ready=0; pcs come out in order; rd_valid=0 after the 5th pop.
//   5 arm and abort in the same cycle while in IDLE -> DONE, count=0. arm alone next cycle -> ARMED, ts=0.
//   6 trace_valid gaps (valid every 3rd cycle) -> ts fields differ by 3; with TS_W=2, ts saturates at 3.

Source files
------------

// File: rtl/mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mips_trace_buffer
// Purpose  : Execution-trace capture for the single-cycle MIPS core. Records
//            one entry per retired instruction into a circular buffer. The
//            entry holds the timestamp, pc, instruction and register
//            write-back. Capture is armed, then triggered on a PC match (or
//            on the first retirement). It runs for a programmable
//            post-trigger count, and the frozen buffer then drains
//            oldest-first over a valid/ready port.
// Ports    : clock, reset_n                    - clock, async active-low reset
//            trace_valid, pc, instruction,
//            reg_write, write_reg, write_data  - retiring instruction
//            arm, abort                        - capture control pulses
//            trig_en, trig_pc, post_count      - trigger configuration
//            rd_valid, rd_ready, rd_data       - oldest-first drain port
//            state, count, overflow, triggered - status
// Revision : 1.0 - initial release
// ============================================================================
module mips_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                trace_valid,
    input  logic [ADDR_W-1:0]                   pc,
    input  logic [31:0]                         instruction,
    input  logic                                reg_write,
    input  logic [4:0]                          write_reg,
    input  logic [DATA_W-1:0]                   write_data,
    input  logic                                arm,
    input  logic                                abort,
    input  logic                                trig_en,
    input  logic [ADDR_W-1:0]                   trig_pc,
    input  logic [$clog2(DEPTH)-1:0]            post_count,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [TS_W+ADDR_W+38+DATA_W-1:0]    rd_data,
    output logic [1:0]                          state,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                overflow,
    output logic                                triggered
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int ENT_W = TS_W + ADDR_W + 38 + DATA_W;

    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_ONE    = IDX_W'(1);
    localparam logic [TS_W-1:0]  C_TS_ONE     = TS_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [IDX_W-1:0]   remaining_q, remaining_d;
    logic               overflow_q, overflow_d;
    logic               triggered_q, triggered_d;

    logic               w_capture;
    logic               w_trigger_hit;
    logic [ENT_W-1:0]   w_entry;

    // Trace storage; contents are deliberately left unreset.
    logic [ENT_W-1:0]   mem_q [DEPTH];

    assign w_entry       = {ts_q, pc, instruction, reg_write, write_reg, write_data};
    assign w_trigger_hit = !trig_en || (pc == trig_pc);

    // post_count is IDX_W bits wide, so it can never exceed DEPTH-1 and the
    // trigger entry is always still in the buffer when capture stops.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ts_d        = ts_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        w_capture   = 1'b0;

        if (abort) begin
            // Freeze in place: contents, count and flags stay untouched.
            state_d = ST_DONE;
        end else if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            ts_d        = '0;
            remaining_d = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end else begin
            if ((state_q == ST_ARMED || state_q == ST_POST) && !(&ts_q)) begin
                ts_d = ts_q + C_TS_ONE;
            end

            case (state_q)
                ST_ARMED: begin
                    if (trace_valid) begin
                        w_capture = 1'b1;
                        if (w_trigger_hit) begin
                            triggered_d = 1'b1;
                            remaining_d = post_count;
                            state_d     = (post_count == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (trace_valid) begin
                        w_capture   = 1'b1;
                        remaining_d = remaining_q - C_IDX_ONE;
                        if (remaining_q == C_IDX_ONE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + C_IDX_ONE;
                        count_d  = count_q - C_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase

            // A full buffer drops its oldest entry by advancing the read side.
            if (w_capture) begin
                wr_ptr_d = wr_ptr_q + C_IDX_ONE;
                if (count_q != C_FULL_COUNT) begin
                    count_d = count_q + C_CNT_ONE;
                end else begin
                    rd_ptr_d   = rd_ptr_q + C_IDX_ONE;
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ts_q        <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ts_q        <= ts_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_capture) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    // Zero-latency read of the oldest entry. It is forced to zero when not
    // valid, so the port shows clean data outside DONE.
    assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign state     = state_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;

endmodule
`default_nettype wire
